// File: rtl/sobel_pkg.sv
// Shared types and helpers for the Sobel front end.
// Window scheduler states and raster counter widths.
package sobel_pkg;

  typedef enum logic [1:0] {
    WIN_IDLE,
    WIN_FILL,
    WIN_RUN
  } win_state_e;

  localparam int unsigned SOBEL_KERNEL = 3;

  function automatic int unsigned col_w(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  function automatic int unsigned row_w(input int unsigned h);
    return (h > 1) ? $clog2(h) : 1;
  endfunction

endpackage

// File: rtl/raster_pos.sv
// Raster col/row counter pair with wrap at the frame edges.
// clr_i with adv_i yields the position following (0,0).
module raster_pos
  import sobel_pkg::*;
#(
  parameter int unsigned WIDTH_P  = 640,
  parameter int unsigned HEIGHT_P = 480,
  localparam int unsigned CW = col_w(WIDTH_P),
  localparam int unsigned RW = row_w(HEIGHT_P)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          adv_i,
  output logic [CW-1:0] col_o,
  output logic [RW-1:0] row_o,
  output logic          last_col_o,
  output logic          last_pix_o
);

  logic [CW-1:0] col_q, col_d, col_b;
  logic [RW-1:0] row_q, row_d, row_b;

  always_comb begin
    col_b = clr_i ? '0 : col_q;
    row_b = clr_i ? '0 : row_q;
    col_d = col_b;
    row_d = row_b;
    if (adv_i) begin
      if (col_b == CW'(WIDTH_P - 1)) begin
        col_d = '0;
        if (row_b == RW'(HEIGHT_P - 1)) begin
          row_d = '0;
        end else begin
          row_d = row_b + 1'b1;
        end
      end else begin
        col_d = col_b + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o      = col_q;
  assign row_o      = row_q;
  assign last_col_o = (col_q == CW'(WIDTH_P - 1));
  assign last_pix_o = last_col_o &
                      (row_q == RW'(HEIGHT_P - 1));

endmodule

// File: rtl/line_window_ctrl.sv
// Line-delay scheduler: raster tracking, buffer advance
// and full-window qualification as one elastic stage.
module line_window_ctrl
  import sobel_pkg::*;
#(
  parameter int unsigned WIDTH_P  = 640,
  parameter int unsigned HEIGHT_P = 480,
  parameter int unsigned KERNEL_P = SOBEL_KERNEL,
  localparam int unsigned CW = col_w(WIDTH_P),
  localparam int unsigned RW = row_w(HEIGHT_P)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          valid_i,
  input  logic          sof_i,
  output logic          ready_o,
  output logic          buf_en_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [CW-1:0] col_o,
  output logic [RW-1:0] row_o,
  output logic          eol_o,
  output logic          eof_o,
  output logic          drop_o,
  output logic          sof_err_o
);

  win_state_e state_q, state_d, step_state;

  logic          accept, active, sof_hit;
  logic [CW-1:0] col, bcol;
  logic [RW-1:0] row, brow;
  logic          last_col, last_pix;
  logic          b_last_col, b_last_pix;
  logic          win, next_run;

  logic          valid_q, valid_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          eol_q, eol_d;
  logic          eof_q, eof_d;
  logic          drop_q, drop_d;
  logic          err_q, err_d;

  assign ready_o  = ~valid_q | ready_i;
  assign accept   = valid_i & ready_o;
  assign active   = (state_q != WIN_IDLE);
  assign sof_hit  = accept & sof_i;
  assign buf_en_o = accept & (active | sof_i);

  raster_pos #(
    .WIDTH_P  (WIDTH_P),
    .HEIGHT_P (HEIGHT_P)
  ) u_pos (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (sof_hit),
    .adv_i      (buf_en_o),
    .col_o      (col),
    .row_o      (row),
    .last_col_o (last_col),
    .last_pix_o (last_pix)
  );

  // A start-of-frame beat is always pixel (0,0), whatever the counters hold.
  always_comb begin
    bcol       = sof_hit ? '0 : col;
    brow       = sof_hit ? '0 : row;
    b_last_col = sof_hit ? (WIDTH_P == 1) : last_col;
    b_last_pix = sof_hit ? (WIDTH_P == 1 && HEIGHT_P == 1)
                         : last_pix;
    win        = (int'(bcol) >= int'(KERNEL_P) - 1) &&
                 (int'(brow) >= int'(KERNEL_P) - 1);
    next_run   = (int'(brow) + (b_last_col ? 1 : 0)) >=
                 (int'(KERNEL_P) - 1);
    if (b_last_pix) begin
      step_state = WIN_IDLE;
    end else if (next_run) begin
      step_state = WIN_RUN;
    end else begin
      step_state = WIN_FILL;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WIN_IDLE: if (sof_hit) state_d = step_state;
      WIN_FILL,
      WIN_RUN:  if (accept)  state_d = step_state;
      default:  state_d = WIN_IDLE;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    col_d   = col_q;
    row_d   = row_q;
    eol_d   = eol_q;
    eof_d   = eof_q;
    drop_d  = accept & ~active & ~sof_i;
    err_d   = sof_hit & active;
    if (accept) begin
      valid_d = buf_en_o & win;
      if (buf_en_o & win) begin
        col_d = bcol;
        row_d = brow;
        eol_d = b_last_col;
        eof_d = b_last_pix;
      end
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= WIN_IDLE;
      valid_q <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      col_q   <= col_d;
      row_q   <= row_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
    end
  end

  assign valid_o   = valid_q;
  assign col_o     = col_q;
  assign row_o     = row_q;
  assign eol_o     = eol_q;
  assign eof_o     = eof_q;
  assign drop_o    = drop_q;
  assign sof_err_o = err_q;

endmodule

// File: tb/tb_line_window_ctrl.sv
// Bench for line_window_ctrl: directed and random beats
// checked against a raster-index reference model.
module tb_line_window_ctrl;

  localparam int W = 8;
  localparam int H = 6;
  localparam int K = 3;

  typedef struct {
    int col;
    int row;
    bit eol;
    bit eof;
  } win_t;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       valid_i = 1'b0;
  logic       sof_i = 1'b0;
  logic       ready_i = 1'b1;
  logic       ready_o, buf_en_o, valid_o;
  logic [2:0] col_o, row_o;
  logic       eol_o, eof_o, drop_o, sof_err_o;

  logic       v2 = 1'b0;
  logic       s2 = 1'b0;
  logic       ready2_o, buf2_o, valid2_o;
  logic [1:0] col2_o, row2_o;
  logic       eol2_o, eof2_o, drop2_o, err2_o;

  int checks = 0;
  int failures = 0;

  win_t q[$];
  bit   in_frame = 0;
  int   p = 0;
  bit   exp_drop = 0;
  bit   exp_err = 0;
  int   n_buf, n_out, n_eol, n_eof, n_drop, n_err, n_frames;
  int   first_col, first_row;

  always #5 clk = ~clk;

  line_window_ctrl #(
    .WIDTH_P (W),
    .HEIGHT_P(H),
    .KERNEL_P(K)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .sof_i    (sof_i),
    .ready_o  (ready_o),
    .buf_en_o (buf_en_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .col_o    (col_o),
    .row_o    (row_o),
    .eol_o    (eol_o),
    .eof_o    (eof_o),
    .drop_o   (drop_o),
    .sof_err_o(sof_err_o)
  );

  line_window_ctrl #(
    .WIDTH_P (3),
    .HEIGHT_P(3),
    .KERNEL_P(3)
  ) dut2 (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .valid_i  (v2),
    .sof_i    (s2),
    .ready_o  (ready2_o),
    .buf_en_o (buf2_o),
    .valid_o  (valid2_o),
    .ready_i  (1'b1),
    .col_o    (col2_o),
    .row_o    (row2_o),
    .eol_o    (eol2_o),
    .eof_o    (eof2_o),
    .drop_o   (drop2_o),
    .sof_err_o(err2_o)
  );

  task automatic chk(input string tag,
                     input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic clr_counts();
    n_buf = 0; n_out = 0; n_eol = 0; n_eof = 0;
    n_drop = 0; n_err = 0; n_frames = 0;
    first_col = -1; first_row = -1;
  endtask

  // One cycle: drive, compare at negedge, advance the model.
  task automatic step(input bit v, input bit s, input bit r);
    bit acc, eb;
    int c, rr;
    win_t w;
    valid_i = v; sof_i = s; ready_i = r;
    @(negedge clk);
    chk("drop_o", drop_o, exp_drop);
    chk("sof_err_o", sof_err_o, exp_err);
    if (drop_o) n_drop++;
    if (sof_err_o) n_err++;
    chk("valid_o", valid_o, q.size() != 0);
    chk("ready_o", ready_o, (q.size() == 0) || r);
    acc = v && ((q.size() == 0) || r);
    if (q.size() != 0) begin
      chk("col_o", col_o, q[0].col);
      chk("row_o", row_o, q[0].row);
      chk("eol_o", eol_o, q[0].eol);
      chk("eof_o", eof_o, q[0].eof);
      if (r) begin
        w = q.pop_front();
        if (first_col < 0) begin
          first_col = w.col; first_row = w.row;
        end
        n_out++;
        if (w.eol) n_eol++;
        if (w.eof) n_eof++;
      end
    end
    eb = acc && (in_frame || s);
    chk("buf_en_o", buf_en_o, eb);
    if (buf_en_o) n_buf++;
    exp_drop = acc && !in_frame && !s;
    exp_err  = acc && in_frame && s;
    if (eb) begin
      if (s) p = 0;
      in_frame = 1;
      c  = p % W;
      rr = p / W;
      if (c >= K - 1 && rr >= K - 1) begin
        w.col = c; w.row = rr;
        w.eol = (c == W - 1);
        w.eof = (c == W - 1) && (rr == H - 1);
        q.push_back(w);
      end
      p++;
      if (p == W * H) begin
        p = 0; in_frame = 0; n_frames++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int guard = 0;
    while (q.size() != 0 && guard < 20) begin
      step(0, 0, 1);
      guard++;
    end
    step(0, 0, 1);
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic do_reset();
    rst_i = 1; valid_i = 0; sof_i = 0;
    @(posedge clk); #1;
    rst_i = 0;
    q.delete();
    in_frame = 0; p = 0;
    exp_drop = 0; exp_err = 0;
  endtask

  initial begin
    int win_per_frame;
    int nwin2, nbuf2;
    bit ok2;
    win_per_frame = (W - K + 1) * (H - K + 1);

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst_i = 0;
    @(negedge clk);
    chk("rst_valid_o", valid_o, 0);
    chk("rst_ready_o", ready_o, 1);
    chk("rst_col_o", col_o, 0);
    chk("rst_row_o", row_o, 0);
    chk("rst_eol_o", eol_o, 0);
    chk("rst_eof_o", eof_o, 0);
    chk("rst_drop_o", drop_o, 0);
    chk("rst_sof_err_o", sof_err_o, 0);
    @(posedge clk); #1;

    // 1: single frame at full rate
    clr_counts();
    for (int i = 0; i < W * H; i++) step(1, i == 0, 1);
    drain();
    chk("t1_buf_en", n_buf, W * H);
    chk("t1_windows", n_out, win_per_frame);
    chk("t1_first_col", first_col, K - 1);
    chk("t1_first_row", first_row, K - 1);
    chk("t1_eol", n_eol, H - K + 1);
    chk("t1_eof", n_eof, 1);

    // 2: random valid/ready over three frames
    clr_counts();
    for (int i = 0; i < 3000 && n_frames < 3; i++) begin
      bit v, r;
      v = 1'($urandom % 2);
      r = 1'($urandom % 2);
      step(v, v && !in_frame, r);
    end
    chk("t2_frames", n_frames, 3);
    drain();
    chk("t2_windows", n_out, 3 * win_per_frame);

    // 3: beats without sof in IDLE are dropped
    clr_counts();
    for (int i = 0; i < 5; i++) step(1, 0, 1);
    for (int i = 0; i < W * H; i++) step(1, i == 0, 1);
    drain();
    chk("t3_drops", n_drop, 5);
    chk("t3_buf_en", n_buf, W * H);
    chk("t3_windows", n_out, win_per_frame);

    // 4: sof mid-frame restarts at (0,0)
    clr_counts();
    for (int i = 0; i < 20; i++) step(1, i == 0, 1);
    for (int i = 0; i < W * H; i++) step(1, i == 0, 1);
    drain();
    chk("t4_sof_err", n_err, 1);
    chk("t4_windows", n_out, 2 + win_per_frame);
    chk("t4_frames", n_frames, 1);

    // 5: reset with a window pending
    clr_counts();
    for (int i = 0; i < 30; i++) step(1, i == 0, 1);
    chk("t5_pre_valid", valid_o, 1);
    do_reset();
    step(0, 0, 1);
    chk("t5_post_valid", valid_o, 0);
    chk("t5_post_ready", ready_o, 1);
    step(1, 0, 1);
    step(0, 0, 1);
    chk("t5_idle_drop", n_drop, 1);

    // 6: 3x3 frame with a 3x3 kernel
    nwin2 = 0; nbuf2 = 0; ok2 = 0;
    for (int i = 0; i < 12; i++) begin
      v2 = (i < 9);
      s2 = (i == 0);
      @(negedge clk);
      if (buf2_o) nbuf2++;
      if (valid2_o) begin
        nwin2++;
        chk("t6_col", col2_o, 2);
        chk("t6_row", row2_o, 2);
        chk("t6_eol", eol2_o, 1);
        chk("t6_eof", eof2_o, 1);
      end
      @(posedge clk); #1;
    end
    v2 = 0; s2 = 0;
    chk("t6_windows", nwin2, 1);
    chk("t6_buf_en", nbuf2, 9);
    chk("t6_ready", ready2_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
